// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state seen by the bus controller.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/coherence_bus_ctrl.sv
// Two-cache snooping bus controller: arbitrates read misses and write-backs to RAM,
// and serves read misses cache-to-cache when the other cache holds the block modified.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [31:0] daddr0,
    input  logic [31:0] daddr1,
    input  logic [31:0] dstore0,
    input  logic [31:0] dstore1,
    input  logic [1:0]  ccwrite,
    input  logic [1:0]  cctrans,
    output logic [1:0]  dwait,
    output logic [31:0] dload0,
    output logic [31:0] dload1,
    output logic [1:0]  ccwait,
    output logic [1:0]  ccinv,
    output logic [31:0] ccsnoopaddr,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate
);

    typedef enum logic [2:0] {
        IDLE, SNOOP, LOAD1, LOAD2, C2C1, C2C2, WB1, WB2
    } state_t;

    state_t      state, next_state;
    logic        g, lg, next_g;
    logic [1:0]  req;
    logic [31:0] addr_g, store_g, store_o;
    logic        access;

    assign req     = dWEN | dREN;
    assign addr_g  = g ? daddr1  : daddr0;
    assign store_g = g ? dstore1 : dstore0;
    assign store_o = g ? dstore0 : dstore1;
    assign access  = (ramstate == ACCESS);

    // lg resets to 1 so cache 0 wins the first tie after reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            g     <= 1'b0;
            lg    <= 1'b1;
        end else begin
            state <= next_state;
            g     <= next_g;
            if (state == IDLE && next_state != IDLE) begin
                lg <= next_g;
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default before the case so no path leaves one unassigned (which would infer a latch).
        next_state  = state;
        next_g      = g;
        dwait       = 2'b11;
        dload0      = '0;
        dload1      = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    next_g     = (req == 2'b11) ? ~lg : req[1];
                    next_state = dWEN[next_g] ? WB1 : SNOOP;
                end
            end

            WB1, WB2: begin
                ramWEN   = 1'b1;
                ramaddr  = addr_g;
                ramstore = store_g;
                if (access) begin
                    dwait[g]   = 1'b0;
                    next_state = (state == WB1) ? WB2 : IDLE;
                end
            end

            SNOOP: begin
                ccwait[~g]  = 1'b1;
                ccsnoopaddr = addr_g;
                ccinv[~g]   = ccwrite[g];
                next_state  = cctrans[~g] ? C2C1 : LOAD1;
            end

            LOAD1, LOAD2: begin
                ccwait[~g]  = 1'b1;
                ccsnoopaddr = addr_g;
                ramREN      = 1'b1;
                ramaddr     = addr_g;
                if (g) dload1 = ramload;
                else   dload0 = ramload;
                if (access) begin
                    dwait[g]   = 1'b0;
                    next_state = (state == LOAD1) ? LOAD2 : IDLE;
                end
            end

            C2C1, C2C2: begin
                // The modified owner's data goes to the requester and is written back to RAM at once.
                ccwait[~g]  = 1'b1;
                ccsnoopaddr = addr_g;
                ramWEN      = 1'b1;
                ramaddr     = addr_g;
                ramstore    = store_o;
                if (g) dload1 = store_o;
                else   dload0 = store_o;
                if (access) begin
                    dwait      = 2'b00;
                    next_state = (state == C2C1) ? C2C2 : IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  dREN, dWEN, ccwrite, cctrans;
    logic [31:0] daddr0, daddr1, dstore0, dstore1, ramload;
    ramstate_t   ramstate;
    logic [1:0]  dwait, ccwait, ccinv;
    logic [31:0] dload0, dload1, ccsnoopaddr, ramaddr, ramstore;
    logic        ramREN, ramWEN;

    int n_checks = 0;
    int n_fail   = 0;

    coherence_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN),
        .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
        .ccwrite(ccwrite), .cctrans(cctrans), .dwait(dwait),
        .dload0(dload0), .dload1(dload1), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // Reference model: one bus transaction at a time, tracked as kind + words completed.
    bit          m_busy, m_write, m_snoop, m_c2c, m_g, m_lg;
    int          m_words;
    logic [1:0]  e_dwait, e_ccwait, e_ccinv;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store, e_load0, e_load1, e_snoop;

    function automatic logic [31:0] pick(bit s, logic [31:0] a0, logic [31:0] a1);
        return s ? a1 : a0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_write = 0; m_snoop = 0; m_c2c = 0; m_g = 0; m_lg = 1; m_words = 0;
    endtask

    task automatic model_outputs();
        logic [31:0] a, own, other;
        bit o;
        o = ~m_g;
        a = pick(m_g, daddr0, daddr1);
        own = pick(m_g, dstore0, dstore1);
        other = pick(o, dstore0, dstore1);
        e_dwait = 2'b11; e_ccwait = 0; e_ccinv = 0; e_ren = 0; e_wen = 0;
        e_addr = 0; e_store = 0; e_load0 = 0; e_load1 = 0; e_snoop = 0;
        if (m_busy && m_write) begin
            e_wen = 1; e_addr = a; e_store = own;
            if (ramstate == ACCESS) e_dwait[m_g] = 1'b0;
        end else if (m_busy) begin
            e_ccwait[o] = 1'b1; e_snoop = a;
            if (m_snoop) begin
                e_ccinv[o] = ccwrite[m_g];
            end else if (m_c2c) begin
                e_wen = 1; e_addr = a; e_store = other;
                if (m_g) e_load1 = other; else e_load0 = other;
                if (ramstate == ACCESS) e_dwait = 2'b00;
            end else begin
                e_ren = 1; e_addr = a;
                if (m_g) e_load1 = ramload; else e_load0 = ramload;
                if (ramstate == ACCESS) e_dwait[m_g] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        logic [1:0] rq;
        bit sel;
        rq = dWEN | dREN;
        if (!m_busy) begin
            if (rq != 0) begin
                sel = (rq == 2'b11) ? ~m_lg : rq[1];
                m_g = sel; m_lg = sel; m_busy = 1; m_words = 0;
                m_write = dWEN[sel];
                m_snoop = !dWEN[sel];
                m_c2c = 0;
            end
        end else if (m_snoop) begin
            m_snoop = 0;
            m_c2c = cctrans[~m_g];
        end else if (ramstate == ACCESS) begin
            m_words++;
            if (m_words == 2) m_busy = 0;
        end
    endtask

    task automatic apply_reset();
        nRST = 0; dREN = 0; dWEN = 0; ccwrite = 0; cctrans = 0;
        daddr0 = 0; daddr1 = 0; dstore0 = 0; dstore1 = 0; ramload = 0; ramstate = FREE;
        repeat (2) @(negedge CLK);
        nRST = 1;
    endtask

    task automatic test_reset();
        nRST = 0; dREN = 2'b11; dWEN = 2'b01; ccwrite = 2'b11; cctrans = 2'b11;
        daddr0 = 32'h40; daddr1 = 32'h80; dstore0 = 32'h1; dstore1 = 32'h2;
        ramload = 32'h3; ramstate = ACCESS;
        repeat (2) @(negedge CLK);
        #1;
        n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL rst_dwait got=%b exp=11", dwait); end
        n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL rst_ram_en got=%b exp=00", {ramREN, ramWEN}); end
        n_checks++; if ({ccwait, ccinv} !== 4'b0) begin n_fail++; $display("FAIL rst_cc got=%b exp=0000", {ccwait, ccinv}); end
        n_checks++; if ({dload0, dload1, ramaddr, ramstore} !== 128'b0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", {dload0, dload1, ramaddr, ramstore}); end
        @(negedge CLK);
        dWEN = 2'b00; dREN = 2'b01; nRST = 1;
        #1;
        n_checks++; if (ccwait !== 2'b00) begin n_fail++; $display("FAIL rst_release_idle got=%b exp=00", ccwait); end
        @(negedge CLK); #1;
        n_checks++; if (ccwait !== 2'b10) begin n_fail++; $display("FAIL first_grant_snoop got=%b exp=10", ccwait); end
        n_checks++; if (ccsnoopaddr !== 32'h40) begin n_fail++; $display("FAIL first_grant_addr got=%h exp=40", ccsnoopaddr); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_w  [10];
        logic [1:0] exp_cw [10];
        exp_w  = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
        exp_cw = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
        apply_reset();
        dREN = 2'b11; daddr0 = 32'h10; daddr1 = 32'h20; ramload = 32'hA5A5_0000; ramstate = ACCESS;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            n_checks++; if (dwait !== exp_w[i]) begin n_fail++; $display("FAIL arb_dwait cyc=%0d got=%b exp=%b", i, dwait, exp_w[i]); end
            n_checks++; if (ccwait !== exp_cw[i]) begin n_fail++; $display("FAIL arb_ccwait cyc=%0d got=%b exp=%b", i, ccwait, exp_cw[i]); end
        end
    endtask

    task automatic test_writeback();
        ramstate_t waits [3];
        int low_cnt;
        waits = '{BUSY, FREE, ERROR};
        low_cnt = 0;
        apply_reset();
        dWEN = 2'b10; daddr1 = 32'h100; dstore1 = 32'hDEAD_0000; ramstate = BUSY;
        #1;
        n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL wb_idle_wen got=%b exp=0", ramWEN); end
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                if (k == 0) begin
                    daddr1 = 32'h100 + 32'(4 * w);
                    dstore1 = 32'hDEAD_0000 + 32'(w);
                    if (w == 1) dWEN = 2'b00;
                end
                ramstate = (k == 3) ? ACCESS : waits[k];
                #1;
                if (dwait[1] === 1'b0) low_cnt++;
                n_checks++; if ({ramWEN, ramREN} !== 2'b10) begin n_fail++; $display("FAIL wb_en w=%0d k=%0d got=%b exp=10", w, k, {ramWEN, ramREN}); end
                n_checks++; if ({ramaddr, ramstore} !== {daddr1, dstore1}) begin n_fail++; $display("FAIL wb_data w=%0d k=%0d got=%h exp=%h", w, k, {ramaddr, ramstore}, {daddr1, dstore1}); end
                n_checks++; if (dwait !== ((k == 3) ? 2'b01 : 2'b11)) begin n_fail++; $display("FAIL wb_dwait w=%0d k=%0d got=%b", w, k, dwait); end
            end
        end
        @(negedge CLK); #1;
        n_checks++; if (low_cnt != 2) begin n_fail++; $display("FAIL wb_low_count got=%0d exp=2", low_cnt); end
        n_checks++; if ({ramWEN, dwait} !== 3'b011) begin n_fail++; $display("FAIL wb_done_idle got=%b exp=011", {ramWEN, dwait}); end
    endtask

    task automatic test_c2c();
        apply_reset();
        dREN = 2'b01; ccwrite = 2'b01; daddr0 = 32'h200; cctrans = 2'b10;
        dstore1 = 32'h1234_5678; ramstate = ACCESS;
        @(negedge CLK); #1;
        n_checks++; if (ccinv !== 2'b10) begin n_fail++; $display("FAIL c2c_ccinv got=%b exp=10", ccinv); end
        n_checks++; if (ccsnoopaddr !== 32'h200) begin n_fail++; $display("FAIL c2c_snoopaddr got=%h exp=200", ccsnoopaddr); end
        n_checks++; if ({dwait, ramREN, ramWEN} !== 4'b1100) begin n_fail++; $display("FAIL c2c_snoop_ctrl got=%b exp=1100", {dwait, ramREN, ramWEN}); end
        for (int w = 0; w < 2; w++) begin
            @(negedge CLK);
            daddr0 = 32'h200 + 32'(4 * w);
            dREN = 2'b00;
            #1;
            n_checks++; if (dload0 !== 32'h1234_5678) begin n_fail++; $display("FAIL c2c_dload0 w=%0d got=%h exp=12345678", w, dload0); end
            n_checks++; if ({ramstore, ramaddr} !== {32'h1234_5678, daddr0}) begin n_fail++; $display("FAIL c2c_ram w=%0d got=%h", w, {ramstore, ramaddr}); end
            n_checks++; if ({dwait, ccinv, ramWEN, ramREN} !== 6'b000010) begin n_fail++; $display("FAIL c2c_ctrl w=%0d got=%b exp=000010", w, {dwait, ccinv, ramWEN, ramREN}); end
        end
        @(negedge CLK); #1;
        n_checks++; if ({ccwait, ramWEN} !== 3'b000) begin n_fail++; $display("FAIL c2c_idle got=%b exp=000", {ccwait, ramWEN}); end
    endtask

    task automatic test_wb_priority();
        apply_reset();
        dREN = 2'b01; dWEN = 2'b01; daddr0 = 32'h300; dstore0 = 32'hCAFE; ramstate = ACCESS;
        @(negedge CLK);
        dWEN = 2'b00;
        #1;
        n_checks++; if ({ramWEN, ccwait, dwait} !== 5'b10010) begin n_fail++; $display("FAIL prio_wb1 got=%b exp=10010", {ramWEN, ccwait, dwait}); end
        @(negedge CLK); #1;
        n_checks++; if ({ramWEN, ramstore} !== {1'b1, 32'hCAFE}) begin n_fail++; $display("FAIL prio_wb2 got=%h", {ramWEN, ramstore}); end
        @(negedge CLK); #1;
        n_checks++; if ({ramWEN, ccwait} !== 3'b000) begin n_fail++; $display("FAIL prio_idle got=%b exp=000", {ramWEN, ccwait}); end
        @(negedge CLK); #1;
        n_checks++; if ({ccwait, ramWEN, ramREN} !== 4'b1000) begin n_fail++; $display("FAIL prio_snoop got=%b exp=1000", {ccwait, ramWEN, ramREN}); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        dREN = 2'b01; daddr0 = 32'h400; ramload = 32'h77; ramstate = ACCESS;
        repeat (3) @(negedge CLK);
        #1;
        n_checks++; if ({ramREN, dwait} !== 3'b110) begin n_fail++; $display("FAIL mid_load2 got=%b exp=110", {ramREN, dwait}); end
        nRST = 0;
        #1;
        n_checks++; if ({ramREN, dwait, ccwait} !== 5'b01100) begin n_fail++; $display("FAIL mid_async_rst got=%b exp=01100", {ramREN, dwait, ccwait}); end
        @(negedge CLK);
        nRST = 1;
        #1;
        n_checks++; if (ccwait !== 2'b00) begin n_fail++; $display("FAIL mid_release_idle got=%b exp=00", ccwait); end
        @(negedge CLK); #1;
        n_checks++; if ({ccwait, ramREN} !== 3'b100) begin n_fail++; $display("FAIL mid_restart_snoop got=%b exp=100", {ccwait, ramREN}); end
    endtask

    task automatic test_random();
        apply_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) @(negedge CLK);
            dREN = 2'($urandom_range(0, 3));
            dWEN = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            ccwrite = 2'($urandom_range(0, 3));
            cctrans = 2'($urandom_range(0, 3));
            daddr0 = $urandom; daddr1 = $urandom; dstore0 = $urandom; dstore1 = $urandom; ramload = $urandom;
            ramstate = ($urandom_range(0, 1) == 1) ? ACCESS : ramstate_t'(2'($urandom_range(0, 3)));
            #1;
            model_outputs();
            n_checks++; if ({dwait, ccwait, ccinv, ramREN, ramWEN} !== {e_dwait, e_ccwait, e_ccinv, e_ren, e_wen})
                begin n_fail++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", i, {dwait, ccwait, ccinv, ramREN, ramWEN}, {e_dwait, e_ccwait, e_ccinv, e_ren, e_wen}); end
            n_checks++; if ({ramaddr, ramstore} !== {e_addr, e_store})
                begin n_fail++; $display("FAIL rnd_ram cyc=%0d got=%h exp=%h", i, {ramaddr, ramstore}, {e_addr, e_store}); end
            n_checks++; if ({dload0, dload1} !== {e_load0, e_load1})
                begin n_fail++; $display("FAIL rnd_dload cyc=%0d got=%h exp=%h", i, {dload0, dload1}, {e_load0, e_load1}); end
            if (e_ccwait != 2'b00) begin
                n_checks++; if (ccsnoopaddr !== e_snoop)
                    begin n_fail++; $display("FAIL rnd_snoopaddr cyc=%0d got=%h exp=%h", i, ccsnoopaddr, e_snoop); end
            end
            n_checks++; if (ramREN === 1'b1 && ramWEN === 1'b1)
                begin n_fail++; $display("FAIL rnd_ren_wen_excl cyc=%0d got=11 exp=not both", i); end
            model_step();
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_writeback();
        test_c2c();
        test_wb_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
